// File: rtl/chan_pkg.sv
// rtl/chan_pkg.sv - shared types and constants for the channel error injector
package chan_pkg;

    typedef enum logic [1:0] {
        PASS     = 2'b00,
        PERIODIC = 2'b01,
        RANDOM   = 2'b10,
        RBURST   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        GUARD = 2'b10
    } burst_st_t;

    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/chan_lfsr16.sv
// rtl/chan_lfsr16.sv - 16-bit Fibonacci LFSR, advances only when adv is high
module chan_lfsr16
    import chan_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] q
);

    // An all-zero state would lock up, so a zero seed falls back to the default
    localparam logic [15:0] INIT = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= INIT;
        end else if (adv) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/chan_err_inj.sv
// rtl/chan_err_inj.sv - registered channel stage that XORs periodic/random/burst errors onto encoder symbols
// Optional error statistics counters are built only when CHAN_STATS_EN is defined.
module chan_err_inj
    import chan_pkg::*;
#(
    parameter int          N         = 4,
    parameter int          WINDOW    = 256,
    parameter logic [8:0]  THRESH    = 9'd16,
    parameter logic [15:0] SEED      = DEFAULT_SEED,
    parameter int          BURST_LEN = 4,
    parameter int          GUARD_LEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic [1:0]  d_in,
    input  logic [1:0]  mode_i,
    input  logic [1:0]  mask_i,
    output logic        valid_o,
    output logic [1:0]  d_out,
    output logic [15:0] err_word_ct,
    output logic [15:0] bad_bit_ct
);

    // The IDLE word is the first burst word, so BURST covers the remaining BURST_LEN-1
    localparam logic [7:0] BURST_LD = (BURST_LEN >= 2) ? 8'(BURST_LEN - 2) : 8'd0;
    localparam logic [7:0] GUARD_LD = (GUARD_LEN >= 1) ? 8'(GUARD_LEN - 1) : 8'd0;

    mode_t       mode;
    burst_st_t   st_q;
    logic [7:0]  cnt_q;
    logic [15:0] word_ct_q;
    logic [15:0] lfsr;
    logic        valid_q;
    logic [1:0]  d_out_q;
    logic        in_win;
    logic        lo_hit;
    logic        hi_hit;
    logic        burst_inj;
    logic [1:0]  m;

    assign mode   = mode_t'(mode_i);
    assign in_win = {16'h0000, word_ct_q} < 32'(WINDOW);
    assign lo_hit = {1'b0, lfsr[7:0]}  < THRESH;
    assign hi_hit = {1'b0, lfsr[15:8]} < THRESH;

    chan_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .adv (enable_i),
        .q   (lfsr)
    );

    always_comb begin
        burst_inj = 1'b0;
        case (st_q)
            IDLE:    burst_inj = lo_hit;
            BURST:   burst_inj = 1'b1;
            default: burst_inj = 1'b0;
        endcase
    end

    always_comb begin
        m = 2'b00;
        if (in_win) begin
            case (mode)
                PERIODIC: m = (word_ct_q[N-1:1] == '0) ? mask_i : 2'b00;
                RANDOM:   m = {lo_hit, hi_hit};
                RBURST:   m = burst_inj ? mask_i : 2'b00;
                default:  m = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q  <= IDLE;
            cnt_q <= 8'd0;
        end else if (enable_i) begin
            if (mode != RBURST) begin
                st_q  <= IDLE;
                cnt_q <= 8'd0;
            end else begin
                case (st_q)
                    IDLE: begin
                        if (lo_hit) begin
                            if (BURST_LEN > 1) begin
                                st_q  <= BURST;
                                cnt_q <= BURST_LD;
                            end else if (GUARD_LEN > 0) begin
                                st_q  <= GUARD;
                                cnt_q <= GUARD_LD;
                            end
                        end
                    end
                    BURST: begin
                        if (cnt_q == 8'd0) begin
                            st_q  <= (GUARD_LEN > 0) ? GUARD : IDLE;
                            cnt_q <= GUARD_LD;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    GUARD: begin
                        if (cnt_q == 8'd0) begin
                            st_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    default: begin
                        st_q  <= IDLE;
                        cnt_q <= 8'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_ct_q <= 16'h0000;
            valid_q   <= 1'b0;
            d_out_q   <= 2'b00;
        end else begin
            valid_q <= enable_i;
            if (enable_i) begin
                d_out_q <= d_in ^ m;
                if (word_ct_q != 16'hFFFF) begin
                    word_ct_q <= word_ct_q + 16'd1;
                end
            end
        end
    end

    assign valid_o = valid_q;
    assign d_out   = d_out_q;

`ifdef CHAN_STATS_EN
    logic [15:0] err_q;
    logic [15:0] bad_q;
    logic [16:0] bad_sum;

    assign bad_sum = {1'b0, bad_q} + {15'd0, m[1]} + {15'd0, m[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 16'h0000;
            bad_q <= 16'h0000;
        end else if (enable_i) begin
            if ((m != 2'b00) && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
            bad_q <= bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
        end
    end

    assign err_word_ct = err_q;
    assign bad_bit_ct  = bad_q;
`else
    assign err_word_ct = 16'h0000;
    assign bad_bit_ct  = 16'h0000;
`endif

endmodule

// File: tb/tb_chan_err_inj.sv
// tb/tb_chan_err_inj.sv - self-checking bench for chan_err_inj with four parameter sets and a reference model
module tb_chan_err_inj;

`ifdef CHAN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en_i = 1'b0;
    logic [1:0] d_i = 2'b00;
    logic [1:0] mode_r = 2'b00;
    logic [1:0] mask_r = 2'b00;

    logic        o_valid [4];
    logic [1:0]  o_dout  [4];
    logic [15:0] o_err   [4];
    logic [15:0] o_bad   [4];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    chan_err_inj u_dflt (
        .clk(clk), .rst(rst), .enable_i(en_i), .d_in(d_i), .mode_i(mode_r), .mask_i(mask_r),
        .valid_o(o_valid[0]), .d_out(o_dout[0]), .err_word_ct(o_err[0]), .bad_bit_ct(o_bad[0]));

    chan_err_inj #(.THRESH(9'd0)) u_t0 (
        .clk(clk), .rst(rst), .enable_i(en_i), .d_in(d_i), .mode_i(mode_r), .mask_i(mask_r),
        .valid_o(o_valid[1]), .d_out(o_dout[1]), .err_word_ct(o_err[1]), .bad_bit_ct(o_bad[1]));

    chan_err_inj #(.THRESH(9'd256), .BURST_LEN(4), .GUARD_LEN(4)) u_t256 (
        .clk(clk), .rst(rst), .enable_i(en_i), .d_in(d_i), .mode_i(mode_r), .mask_i(mask_r),
        .valid_o(o_valid[2]), .d_out(o_dout[2]), .err_word_ct(o_err[2]), .bad_bit_ct(o_bad[2]));

    chan_err_inj #(.THRESH(9'd128), .SEED(16'h0000), .BURST_LEN(1), .GUARD_LEN(0)) u_edge (
        .clk(clk), .rst(rst), .enable_i(en_i), .d_in(d_i), .mode_i(mode_r), .mask_i(mask_r),
        .valid_o(o_valid[3]), .d_out(o_dout[3]), .err_word_ct(o_err[3]), .bad_bit_ct(o_bad[3]));

    int p_thresh [4] = '{16, 0, 256, 128};
    int p_bl     [4] = '{4, 4, 4, 1};
    int p_gl     [4] = '{8, 8, 4, 0};

    // Burst position is tracked as "words of burst/guard still owed", not as states
    int          m_wc   [4];
    logic [15:0] m_l    [4];
    int          m_brem [4];
    int          m_grem [4];
    logic [1:0]  m_dout [4];
    logic        m_valid[4];
    int          m_err  [4];
    int          m_bad  [4];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_wc[k] = 0; m_l[k] = 16'hACE1; m_brem[k] = 0; m_grem[k] = 0;
            m_dout[k] = 2'b00; m_valid[k] = 1'b0; m_err[k] = 0; m_bad[k] = 0;
        end
    endtask

    task automatic model_step(input logic en, input logic [1:0] d, input logic [1:0] mode,
                              input logic [1:0] mask);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] m;
            logic inj;
            m = 2'b00;
            inj = 1'b0;
            m_valid[k] = en;
            if (en) begin
                if (mode == 2'b11) begin
                    if (m_brem[k] > 0) begin
                        inj = 1'b1;
                        m_brem[k] = m_brem[k] - 1;
                        if (m_brem[k] == 0) m_grem[k] = p_gl[k];
                    end else if (m_grem[k] > 0) begin
                        m_grem[k] = m_grem[k] - 1;
                    end else if (int'(m_l[k][7:0]) < p_thresh[k]) begin
                        inj = 1'b1;
                        m_brem[k] = p_bl[k] - 1;
                        if (m_brem[k] == 0) m_grem[k] = p_gl[k];
                    end
                end else begin
                    m_brem[k] = 0;
                    m_grem[k] = 0;
                end
                if (m_wc[k] < 256) begin
                    case (mode)
                        2'b01: if ((m_wc[k] % 16) < 2) m = mask;
                        2'b10: m = {int'(m_l[k][7:0]) < p_thresh[k], int'(m_l[k][15:8]) < p_thresh[k]};
                        2'b11: if (inj) m = mask;
                        default: m = 2'b00;
                    endcase
                end
                m_dout[k] = d ^ m;
                if (m != 2'b00 && m_err[k] < 65535) m_err[k] = m_err[k] + 1;
                m_bad[k] = m_bad[k] + int'(m[1]) + int'(m[0]);
                if (m_bad[k] > 65535) m_bad[k] = 65535;
                if (m_wc[k] < 65535) m_wc[k] = m_wc[k] + 1;
                m_l[k] = {m_l[k][14:0], m_l[k][15] ^ m_l[k][13] ^ m_l[k][12] ^ m_l[k][10]};
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 4; k++) begin
            logic [15:0] ee, eb;
            ee = STATS ? 16'(m_err[k]) : 16'h0000;
            eb = STATS ? 16'(m_bad[k]) : 16'h0000;
            check($sformatf("%s inst%0d {valid,dout,err,bad}", tag, k),
                  {29'd0, o_valid[k], o_dout[k], o_err[k], o_bad[k]},
                  {29'd0, m_valid[k], m_dout[k], ee, eb});
        end
    endtask

    task automatic cycle(input logic en, input logic [1:0] d, input logic [1:0] mode,
                         input logic [1:0] mask, input string tag);
        @(negedge clk);
        en_i = en; d_i = d; mode_r = mode; mask_r = mask;
        model_step(en, d, mode, mask);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; en_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct packed {
        logic       en;
        logic [1:0] d;
        logic [1:0] mode;
        logic [1:0] mask;
        logic       exp_v;
        logic [1:0] exp_d;
    } vec_t;

    vec_t tv [7];

    initial begin
        tv[0] = '{1'b1, 2'b10, 2'b01, 2'b11, 1'b1, 2'b01};
        tv[1] = '{1'b1, 2'b01, 2'b01, 2'b11, 1'b1, 2'b10};
        tv[2] = '{1'b0, 2'b11, 2'b01, 2'b11, 1'b0, 2'b10};
        tv[3] = '{1'b0, 2'b00, 2'b01, 2'b11, 1'b0, 2'b10};
        tv[4] = '{1'b1, 2'b11, 2'b01, 2'b11, 1'b1, 2'b11};
        tv[5] = '{1'b1, 2'b10, 2'b00, 2'b11, 1'b1, 2'b10};
        tv[6] = '{1'b1, 2'b00, 2'b01, 2'b01, 1'b1, 2'b00};

        do_reset();
        #1;
        check_all("reset");

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            en_i = tv[i].en; d_i = tv[i].d; mode_r = tv[i].mode; mask_r = tv[i].mask;
            @(posedge clk);
            #1;
            check($sformatf("table[%0d] {valid,dout}", i), {61'd0, o_valid[0], o_dout[0]},
                  {61'd0, tv[i].exp_v, tv[i].exp_d});
        end

        do_reset();
        for (int i = 0; i < 300; i++) cycle(1'b1, 2'($urandom), 2'b00, 2'($urandom), "pass");
        check("pass err_word_ct", {48'd0, o_err[0]}, 64'd0);

        do_reset();
        for (int i = 0; i < 300; i++) cycle(1'b1, 2'($urandom), 2'b01, 2'b11, "periodic");
        check("periodic err_word_ct", {48'd0, o_err[0]}, STATS ? 64'd32 : 64'd0);
        check("periodic bad_bit_ct", {48'd0, o_bad[0]}, STATS ? 64'd64 : 64'd0);

        do_reset();
        for (int i = 0; i < 256; i++) cycle(1'b1, 2'($urandom), 2'b10, 2'($urandom), "random");
        check("random thresh0 bad_bit_ct", {48'd0, o_bad[1]}, 64'd0);
        check("random thresh256 bad_bit_ct", {48'd0, o_bad[2]}, STATS ? 64'd512 : 64'd0);

        do_reset();
        for (int i = 0; i < 256; i++) cycle(1'b1, 2'($urandom), 2'b11, 2'b01, "rburst");
        check("rburst thresh256 err_word_ct", {48'd0, o_err[2]}, STATS ? 64'd128 : 64'd0);

        do_reset();
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 2'($urandom), 2'b01, 2'b11, "periodic gaps");

        do_reset();
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 2'($urandom), 2'b11, 2'($urandom), "rburst gaps");

        do_reset();
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom), 2'($urandom), "mixed");

        do_reset();
        cycle(1'b1, 2'b00, 2'b11, 2'b01, "pre-abort");
        cycle(1'b1, 2'b10, 2'b11, 2'b01, "pre-abort");
        rst = 1'b0;
        en_i = 1'b0;
        #1;
        check("async reset inst2 outputs", {29'd0, o_valid[2], o_dout[2], o_err[2], o_bad[2]}, 64'd0);
        model_reset();
        check_all("async reset");
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 2'b10, 2'b11, 2'b01, "post-abort");
        check("post-abort first word", {62'd0, o_dout[2]}, 64'd3);
        for (int i = 0; i < 40; i++) cycle(1'b1, 2'($urandom), 2'b11, 2'b01, "post-abort");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
